cp0_exception_ctrl: RTL and testbench



---
 rtl/cp0_exception_ctrl_if.sv | 33 +++
 rtl/cp0_exception_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cp0_exception_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cp0_exception_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exception_ctrl_if
// Description : Pipeline <-> CP0 exception controller bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface cp0_exception_ctrl_if #(
    parameter int IRQ_W = 6
);
    logic             insValid;
    logic [2:0]       cp0Op;
    logic [31:0]      pc;
    logic [4:0]       regAddr;
    logic [31:0]      wData;
    logic [IRQ_W-1:0] irq;
    logic [31:0]      rData;
    logic             flush;
    logic             stall;
    logic             redirect;
    logic [31:0]      targetPc;
    logic             exl;

    modport master (
        output insValid, cp0Op, pc, regAddr, wData, irq,
        input  rData, flush, stall, redirect, targetPc, exl
    );

    modport slave (
        input  insValid, cp0Op, pc, regAddr, wData, irq,
        output rData, flush, stall, redirect, targetPc, exl
    );
endinterface
`default_nettype wire

// File: rtl/cp0_exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cp0_exception_ctrl
// Description : CP0 Status/Cause/EPC and exception entry / ERET sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_exception_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          IRQ_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    cp0_exception_ctrl_if.slave  bus
);
    localparam logic [1:0]  c_idle     = 2'd0;
    localparam logic [1:0]  c_flush    = 2'd1;
    localparam logic [1:0]  c_redirect = 2'd2;

    localparam logic [2:0]  c_op_mtc0  = 3'b010;
    localparam logic [2:0]  c_op_sys   = 3'b011;
    localparam logic [2:0]  c_op_eret  = 3'b100;

    localparam logic [4:0]  c_exc_int  = 5'd0;
    localparam logic [4:0]  c_exc_sys  = 5'd8;
    localparam logic [31:0] c_prid     = 32'h0000_0001;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_ie;
    logic             r_exl;
    logic [IRQ_W-1:0] r_im;
    logic [IRQ_W-1:0] r_ip;
    logic [4:0]       r_exc_code;
    logic [31:0]      r_epc;
    logic [31:0]      r_tgt;
    logic [31:0]      r_target_pc;

    logic             w_int_pend;
    logic             w_take_int;
    logic             w_take_sys;
    logic             w_take_eret;
    logic             w_mtc0;
    logic             w_flush;
    logic             w_stall;
    logic             w_redirect;
    logic [31:0]      w_status_word;
    logic [31:0]      w_cause_word;
    logic [31:0]      w_rdata;

    assign w_int_pend = r_ie & ~r_exl & (|(r_ip & r_im));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Events are only recognised in IDLE; interrupts outrank every cp0Op.
    always_comb begin
        w_state_nxt = r_state;
        w_take_int  = 1'b0;
        w_take_sys  = 1'b0;
        w_take_eret = 1'b0;
        w_mtc0      = 1'b0;
        w_flush     = 1'b0;
        w_stall     = 1'b0;
        w_redirect  = 1'b0;
        case (r_state)
            c_idle: begin
                if (bus.insValid) begin
                    if (w_int_pend) begin
                        w_take_int  = 1'b1;
                        w_state_nxt = c_flush;
                    end else if (bus.cp0Op == c_op_sys) begin
                        w_take_sys  = 1'b1;
                        w_state_nxt = c_flush;
                    end else if (bus.cp0Op == c_op_eret) begin
                        w_take_eret = 1'b1;
                        w_state_nxt = c_flush;
                    end else if (bus.cp0Op == c_op_mtc0) begin
                        w_mtc0      = 1'b1;
                    end
                end
            end
            c_flush: begin
                w_flush     = 1'b1;
                w_stall     = 1'b1;
                w_state_nxt = c_redirect;
            end
            c_redirect: begin
                w_redirect  = 1'b1;
                w_stall     = 1'b1;
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ie        <= 1'b0;
            r_exl       <= 1'b0;
            r_im        <= '0;
            r_ip        <= '0;
            r_exc_code  <= '0;
            r_epc       <= '0;
            r_tgt       <= '0;
            r_target_pc <= '0;
        end else begin
            r_ip <= bus.irq;
            // Load the visible target one cycle early so it is valid throughout REDIRECT and held afterwards.
            if (r_state == c_flush) begin
                r_target_pc <= r_tgt;
            end
            if (w_take_int || w_take_sys) begin
                r_epc      <= bus.pc;
                r_exc_code <= w_take_int ? c_exc_int : c_exc_sys;
                r_exl      <= 1'b1;
                r_tgt      <= EXC_VECTOR;
            end else if (w_take_eret) begin
                r_exl      <= 1'b0;
                r_tgt      <= r_epc;
            end else if (w_mtc0) begin
                case (bus.regAddr)
                    5'd12: begin
                        r_ie  <= bus.wData[0];
                        r_exl <= bus.wData[1];
                        r_im  <= bus.wData[10 +: IRQ_W];
                    end
                    5'd13:   r_exc_code <= bus.wData[6:2];
                    5'd14:   r_epc      <= bus.wData;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        w_status_word              = '0;
        w_status_word[0]           = r_ie;
        w_status_word[1]           = r_exl;
        w_status_word[10 +: IRQ_W] = r_im;
        w_cause_word               = '0;
        w_cause_word[10 +: IRQ_W]  = r_ip;
        w_cause_word[6:2]          = r_exc_code;
        case (bus.regAddr)
            5'd12:   w_rdata = w_status_word;
            5'd13:   w_rdata = w_cause_word;
            5'd14:   w_rdata = r_epc;
            5'd15:   w_rdata = c_prid;
            default: w_rdata = '0;
        endcase
    end

    assign bus.rData    = w_rdata;
    assign bus.flush    = w_flush;
    assign bus.stall    = w_stall;
    assign bus.redirect = w_redirect;
    assign bus.targetPc = r_target_pc;
    assign bus.exl      = r_exl;
endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cp0_exception_ctrl
// Description : Vector-table bench with expected-output scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_exception_ctrl;
    localparam logic [2:0] c_nop  = 3'b000;
    localparam logic [2:0] c_mfc0 = 3'b001;
    localparam logic [2:0] c_mtc0 = 3'b010;
    localparam logic [2:0] c_sys  = 3'b011;
    localparam logic [2:0] c_eret = 3'b100;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [2:0]  op;
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [5:0]  irq;
        logic        flush;
        logic        stall;
        logic        redirect;
        logic [31:0] tpc;
        logic        exl;
        logic        chk_rd;
        logic [31:0] rd;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;
    vec_t vecs[$];
    vec_t expq[$];

    cp0_exception_ctrl_if #(.IRQ_W(6)) bus ();

    cp0_exception_ctrl #(
        .EXC_VECTOR (32'h0000_4180),
        .IRQ_W      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic iv, input logic [2:0] op,
                                input logic [31:0] pc, input logic [4:0] a,
                                input logic [31:0] wd, input logic [5:0] irq,
                                input logic f, input logic s, input logic rdr,
                                input logic [31:0] tpc, input logic x,
                                input logic chk, input logic [31:0] rdv);
        vec_t v;
        v.rst = r;  v.iv = iv;  v.op = op;  v.pc = pc;  v.addr = a;  v.wd = wd;  v.irq = irq;
        v.flush = f;  v.stall = s;  v.redirect = rdr;  v.tpc = tpc;  v.exl = x;
        v.chk_rd = chk;  v.rd = rdv;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc%0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (expq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard cyc%0d: got empty queue want entry", cyc);
            return;
        end
        e = expq.pop_front();
        cmp("flush",    {31'b0, bus.flush},    {31'b0, e.flush});
        cmp("stall",    {31'b0, bus.stall},    {31'b0, e.stall});
        cmp("redirect", {31'b0, bus.redirect}, {31'b0, e.redirect});
        cmp("targetPc", bus.targetPc,          e.tpc);
        cmp("exl",      {31'b0, bus.exl},      {31'b0, e.exl});
        if (e.chk_rd) cmp("rData", bus.rData, e.rd);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst          = v.rst;
        bus.insValid = v.iv;
        bus.cp0Op    = v.op;
        bus.pc       = v.pc;
        bus.regAddr  = v.addr;
        bus.wData    = v.wd;
        bus.irq      = v.irq;
        expq.push_back(v);
        @(posedge clk);
        #1;
        check_out();
        cyc++;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst = 1'b1;
        bus.insValid = 1'b0;  bus.cp0Op = c_nop;  bus.pc = '0;
        bus.regAddr = '0;     bus.wData = '0;     bus.irq = '0;

        //                  rst iv op      pc            a      wd            irq       f  s  r  tpc           x  chk rd
        // reset, Status write, PRId read-only
        vecs.push_back(mk(1, 0, c_nop,  32'h0,      5'd12, 32'h0,        6'h00, 0, 0, 0, 32'h0,      0, 1, 32'h0));
        vecs.push_back(mk(0, 1, c_mtc0, 32'h0,      5'd12, 32'h0000_0401, 6'h00, 0, 0, 0, 32'h0,      0, 1, 32'h0000_0401));
        vecs.push_back(mk(0, 1, c_mfc0, 32'h0,      5'd15, 32'h0,        6'h00, 0, 0, 0, 32'h0,      0, 1, 32'h0000_0001));
        vecs.push_back(mk(0, 1, c_mtc0, 32'h0,      5'd15, 32'hFFFF_FFFF, 6'h00, 0, 0, 0, 32'h0,      0, 1, 32'h0000_0001));
        vecs.push_back(mk(0, 1, c_mfc0, 32'h0,      5'd12, 32'h0,        6'h00, 0, 0, 0, 32'h0,      0, 1, 32'h0000_0401));
        // SYSCALL; MTC0 EPC during FLUSH must be ignored
        vecs.push_back(mk(0, 1, c_sys,  32'h3010,   5'd14, 32'h0,        6'h00, 1, 1, 0, 32'h0,      1, 1, 32'h0000_3010));
        vecs.push_back(mk(0, 1, c_mtc0, 32'h0,      5'd14, 32'hDEAD_BEEF, 6'h00, 0, 1, 1, 32'h4180,   1, 1, 32'h0000_3010));
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd13, 32'h0,        6'h00, 0, 0, 0, 32'h4180,   1, 1, 32'h0000_0020));
        // ERET back to EPC
        vecs.push_back(mk(0, 1, c_eret, 32'h0,      5'd12, 32'h0,        6'h00, 1, 1, 0, 32'h4180,   0, 1, 32'h0000_0401));
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd12, 32'h0,        6'h00, 0, 1, 1, 32'h3010,   0, 1, 32'h0000_0401));
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd12, 32'h0,        6'h00, 0, 0, 0, 32'h3010,   0, 0, 32'h0));
        // irq sampled one cycle late; insValid=0 blocks; interrupt beats SYSCALL
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd13, 32'h0,        6'h01, 0, 0, 0, 32'h3010,   0, 1, 32'h0000_0420));
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd13, 32'h0,        6'h01, 0, 0, 0, 32'h3010,   0, 1, 32'h0000_0420));
        vecs.push_back(mk(0, 1, c_sys,  32'h3020,   5'd14, 32'h0,        6'h01, 1, 1, 0, 32'h3010,   1, 1, 32'h0000_3020));
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd13, 32'h0,        6'h00, 0, 1, 1, 32'h4180,   1, 1, 32'h0000_0000));
        // second irq pulse while EXL=1 is not taken
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd13, 32'h0,        6'h01, 0, 0, 0, 32'h4180,   1, 1, 32'h0000_0400));
        vecs.push_back(mk(0, 1, c_nop,  32'h3030,   5'd13, 32'h0,        6'h01, 0, 0, 0, 32'h4180,   1, 1, 32'h0000_0400));
        // IE=0 with all irqs, then IE=1 with IM=0
        vecs.push_back(mk(0, 1, c_mtc0, 32'h0,      5'd12, 32'h0000_FC00, 6'h3F, 0, 0, 0, 32'h4180,   0, 1, 32'h0000_FC00));
        vecs.push_back(mk(0, 1, c_nop,  32'h3034,   5'd13, 32'h0,        6'h3F, 0, 0, 0, 32'h4180,   0, 1, 32'h0000_FC00));
        vecs.push_back(mk(0, 1, c_mtc0, 32'h0,      5'd12, 32'h0000_0001, 6'h3F, 0, 0, 0, 32'h4180,   0, 1, 32'h0000_0001));
        vecs.push_back(mk(0, 1, c_nop,  32'h3038,   5'd12, 32'h0,        6'h3F, 0, 0, 0, 32'h4180,   0, 1, 32'h0000_0001));
        // enabled interrupt waits for insValid
        vecs.push_back(mk(0, 1, c_mtc0, 32'h0,      5'd12, 32'h0000_0401, 6'h3F, 0, 0, 0, 32'h4180,   0, 1, 32'h0000_0401));
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd12, 32'h0,        6'h3F, 0, 0, 0, 32'h4180,   0, 1, 32'h0000_0401));
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd12, 32'h0,        6'h3F, 0, 0, 0, 32'h4180,   0, 1, 32'h0000_0401));
        vecs.push_back(mk(0, 1, c_nop,  32'h3040,   5'd14, 32'h0,        6'h3F, 1, 1, 0, 32'h4180,   1, 1, 32'h0000_3040));
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd14, 32'h0,        6'h00, 0, 1, 1, 32'h4180,   1, 1, 32'h0000_3040));
        vecs.push_back(mk(0, 0, c_nop,  32'h0,      5'd14, 32'h0,        6'h00, 0, 0, 0, 32'h4180,   1, 1, 32'h0000_3040));

        foreach (vecs[i]) apply(vecs[i]);

        // Reset asserted during FLUSH, then a clean SYSCALL
        apply(mk(0, 1, c_sys,  32'h3050, 5'd14, 32'h0, 6'h00, 1, 1, 0, 32'h4180, 1, 1, 32'h0000_3050));
        apply(mk(1, 1, c_sys,  32'h3054, 5'd14, 32'h0, 6'h00, 0, 0, 0, 32'h0,    0, 1, 32'h0));
        apply(mk(0, 1, c_sys,  32'h3060, 5'd13, 32'h0, 6'h00, 1, 1, 0, 32'h0,    1, 1, 32'h0000_0020));
        apply(mk(0, 0, c_nop,  32'h0,    5'd14, 32'h0, 6'h00, 0, 1, 1, 32'h4180, 1, 1, 32'h0000_3060));
        apply(mk(0, 0, c_nop,  32'h0,    5'd14, 32'h0, 6'h00, 0, 0, 0, 32'h4180, 1, 1, 32'h0000_3060));

        // ERET, then ERET again with EXL already clear still returns to EPC
        apply(mk(0, 1, c_eret, 32'h0,    5'd12, 32'h0, 6'h00, 1, 1, 0, 32'h4180, 0, 1, 32'h0));
        apply(mk(0, 0, c_nop,  32'h0,    5'd12, 32'h0, 6'h00, 0, 1, 1, 32'h3060, 0, 0, 32'h0));
        apply(mk(0, 0, c_nop,  32'h0,    5'd12, 32'h0, 6'h00, 0, 0, 0, 32'h3060, 0, 0, 32'h0));
        apply(mk(0, 1, c_mtc0, 32'h0,    5'd14, 32'h0000_5000, 6'h00, 0, 0, 0, 32'h3060, 0, 1, 32'h0000_5000));
        apply(mk(0, 1, c_eret, 32'h0,    5'd12, 32'h0, 6'h00, 1, 1, 0, 32'h3060, 0, 0, 32'h0));
        apply(mk(0, 0, c_nop,  32'h0,    5'd12, 32'h0, 6'h00, 0, 1, 1, 32'h5000, 0, 0, 32'h0));
        apply(mk(0, 0, c_nop,  32'h0,    5'd99 % 32, 32'h0, 6'h00, 0, 0, 0, 32'h5000, 0, 1, 32'h0));

        if (expq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
